// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared types and constants for the RTC bus arbiter: FSM encoding,
// requester indices and default strobe/gap timing.
package rtc_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int NUM_REQ  = 3;
    localparam int REQ_POLL = 0;
    localparam int REQ_DATE = 1;
    localparam int REQ_TSET = 2;

    localparam int DEF_STROBE_CYC = 8;
    localparam int DEF_GAP_CYC    = 2;

    // The first contest after reset starts scanning at requester 0.
    localparam logic [1:0] RR_PTR_INIT = 2'(REQ_TSET);

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        if (oh[REQ_TSET])
            return 2'(REQ_TSET);
        else if (oh[REQ_DATE])
            return 2'(REQ_DATE);
        else
            return 2'(REQ_POLL);
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// Combinational 3-way round-robin selector: scans from the requester after
// ptr, wrapping 2->0, and returns the first active one as a one-hot winner.
module rtc_rr_pick
    import rtc_bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [1:0] cand;

    always_comb begin
        winner = '0;
        valid  = |req;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((int'(ptr) + k) % NUM_REQ);
            if (winner == '0 && req[cand])
                winner[cand] = 1'b1;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing one multiplexed RTC bus between three
// requesters: address phase, idle gap, then a read or write data phase.
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   rnw,
    input  logic [8*NUM_REQ-1:0] addr_in,
    input  logic [8*NUM_REQ-1:0] wdata_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic [7:0]           bus_out,
    output logic                 bus_oe,
    input  logic [7:0]           bus_in,
    output logic                 cs_n,
    output logic                 ad_sel,
    output logic                 rd_n,
    output logic                 wr_n
);

    // Counters load N-1 on phase entry and leave the phase when they hit 0.
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYC - 1);

    state_t             state;
    logic [7:0]         phase_cnt;
    logic [1:0]         rr_ptr;
    logic [7:0]         wdata_lat;
    logic               rnw_lat;

    logic [NUM_REQ-1:0] pick_winner;
    logic               pick_valid;
    logic [7:0]         addr_bytes  [NUM_REQ];
    logic [7:0]         wdata_bytes [NUM_REQ];
    logic [7:0]         sel_addr;
    logic [7:0]         sel_wdata;
    logic               sel_rnw;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_bytes[gi]  = addr_in[8*gi +: 8];
            assign wdata_bytes[gi] = wdata_in[8*gi +: 8];
        end
    endgenerate

    rtc_rr_pick u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rnw   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_winner[i]) begin
                sel_addr  = addr_bytes[i];
                sel_wdata = wdata_bytes[i];
                sel_rnw   = rnw[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            rr_ptr    <= RR_PTR_INIT;
            wdata_lat <= '0;
            rnw_lat   <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            bus_out   <= '0;
            bus_oe    <= 1'b0;
            cs_n      <= 1'b1;
            ad_sel    <= 1'b0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_ADDR;
                        phase_cnt <= STROBE_LOAD;
                        gnt       <= pick_winner;
                        wdata_lat <= sel_wdata;
                        rnw_lat   <= sel_rnw;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        ad_sel    <= 1'b1;
                        bus_oe    <= 1'b1;
                        bus_out   <= sel_addr;
                        wr_n      <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (phase_cnt == 8'd0) begin
                        state     <= ST_GAP;
                        phase_cnt <= GAP_LOAD;
                        wr_n      <= 1'b1;
                        bus_oe    <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == 8'd0) begin
                        state     <= ST_DATA;
                        phase_cnt <= STROBE_LOAD;
                        ad_sel    <= 1'b0;
                        if (rnw_lat) begin
                            rd_n    <= 1'b0;
                        end else begin
                            bus_oe  <= 1'b1;
                            bus_out <= wdata_lat;
                            wr_n    <= 1'b0;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                ST_DATA: begin
                    if (phase_cnt == 8'd0) begin
                        // This edge closes the last strobe cycle, so bus_in is
                        // still being driven by the RTC under rd_n low.
                        if (rnw_lat)
                            rdata <= bus_in;
                        state  <= ST_DONE;
                        done   <= gnt;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        cs_n   <= 1'b1;
                        bus_oe <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    rr_ptr <= onehot_to_idx(gnt);
                    gnt    <= '0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
